// File: rtl/pitch_map_pkg.sv
// Shared types and elaboration-time helpers for the pitch-to-speed mapper.
//   state_t       : frame-processing FSM states
//   calc_map_w    : width of a level value 1..LEVELS
//   calc_qw       : quotient width, one divider cycle per bit
//   calc_step     : number of levels per speed band
//   band          : level -> speed code, saturating at the top code
package pitch_map_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    AVG,
    DECIDE
  } state_t;

  function automatic int unsigned calc_map_w(input int unsigned levels);
    return $clog2(levels + 1);
  endfunction

  function automatic int unsigned calc_qw(input int unsigned levels);
    return $clog2(levels);
  endfunction

  function automatic int unsigned calc_step(input int unsigned levels, input int unsigned nspeed);
    return levels / nspeed;
  endfunction

  // Speed band of a level; STEP is a power of two so the divide is a shift.
  function automatic int unsigned band(input int unsigned x, input int unsigned step_log2,
                                       input int unsigned nspeed);
    int unsigned b;
    b = x >> step_log2;
    return (b > nspeed - 1) ? nspeed - 1 : b;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
//   clk, rst_n : clock, async active-low reset
//   start      : load dividend/divisor; QUOT_W iterations follow
//   dividend   : numerator, must satisfy dividend < divisor * 2**QUOT_W
//   divisor    : denominator, non-zero
//   quotient   : registered result, valid from the cycle after done_c
//   done_c     : high during the cycle whose edge retires the last bit
module seq_divider #(
  parameter int unsigned DIVIDEND_W = 14,
  parameter int unsigned DIVISOR_W  = 9,
  parameter int unsigned QUOT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done_c
);

  localparam int unsigned CW    = DIVIDEND_W + DIVISOR_W + QUOT_W;
  localparam int unsigned CNT_W = (QUOT_W > 1) ? $clog2(QUOT_W) : 1;

  logic [CW-1:0]    rem;
  logic [CW-1:0]    ddiv;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             fits_c;

  // Trial subtraction against the divisor aligned to the current quotient bit.
  assign fits_c = (rem >= ddiv);
  assign done_c = busy && (cnt == '0);

  // Iteration: subtract if it fits, shift quotient left, move divisor down one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      ddiv     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      rem      <= CW'(dividend);
      ddiv     <= CW'(divisor) << (QUOT_W - 1);
      cnt      <= CNT_W'(QUOT_W - 1);
      busy     <= 1'b1;
      quotient <= '0;
    end else if (busy) begin
      if (fits_c) begin
        rem <= rem - ddiv;
      end
      quotient <= QUOT_W'({quotient, fits_c});
      ddiv     <= ddiv >> 1;
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pitch_speed_mapper.sv
// Maps a per-frame pitch index to a level 1..LEVELS, averages it, and
// derives a debounced, hysteretic drive speed code.
//   clk, reset   : clock, async active-low reset
//   in_data      : pitch index; in_valid/in_ready handshake
//   mapped_value : instantaneous level of the last frame
//   avg_value    : moving-average level
//   speed        : filtered speed code
//   out_valid    : one-cycle pulse when the outputs above update
//   changed      : one-cycle pulse with out_valid when speed moved
module pitch_speed_mapper
  import pitch_map_pkg::*;
#(
  parameter int unsigned PITCH_W   = 10,
  parameter int unsigned PITCH_MAX = 300,
  parameter int unsigned LEVELS    = 16,
  parameter int unsigned NSPEED    = 4,
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned HYST      = 1,
  parameter int unsigned HOLD      = 3,
  localparam int unsigned MAP_W    = calc_map_w(LEVELS),
  localparam int unsigned SPD_W    = (NSPEED > 1) ? $clog2(NSPEED) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PITCH_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [MAP_W-1:0]   mapped_value,
  output logic [MAP_W-1:0]   avg_value,
  output logic [SPD_W-1:0]   speed,
  output logic               out_valid,
  output logic               changed
);

  localparam int unsigned QW        = calc_qw(LEVELS);
  localparam int unsigned STEP      = calc_step(LEVELS, NSPEED);
  localparam int unsigned STEP_LOG2 = $clog2(STEP);
  localparam int unsigned NUM_W     = PITCH_W + QW;
  localparam int unsigned DIVR_W    = $clog2(PITCH_MAX + 1);
  localparam int unsigned AVG_N     = 1 << AVG_LOG2;
  localparam int unsigned WP_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SUM_W     = MAP_W + AVG_LOG2;
  localparam int unsigned CNT_W     = $clog2(HOLD + 1);

  state_t             state_q;
  state_t             state_d;
  logic [PITCH_W-1:0] pitch_q;
  logic [NUM_W-1:0]   num_c;
  logic [QW-1:0]      quot;
  logic               div_done_c;
  logic               div_start_c;
  logic [MAP_W-1:0]   mapped_c;
  logic [MAP_W-1:0]   avg_buf [AVG_N];
  logic [WP_W-1:0]    wp;
  logic [SUM_W-1:0]   sum;
  logic [MAP_W-1:0]   avg_c;
  logic [SPD_W-1:0]   pending;
  logic [CNT_W-1:0]   hold_cnt;

  logic [SPD_W-1:0]   cand_c;
  logic [SPD_W-1:0]   speed_nxt_c;
  logic [SPD_W-1:0]   pending_nxt_c;
  logic [CNT_W-1:0]   cnt_nxt_c;
  logic               changed_nxt_c;
  int unsigned        avg_i;
  int unsigned        spd_i;
  int unsigned        band_avg;
  int unsigned        lim_i;
  int unsigned        cand_i;

  assign in_ready = (state_q == IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DIV lasts exactly QW cycles, paced by the divider.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MUL;
      MUL:     state_d = DIV;
      DIV:     if (div_done_c) state_d = AVG;
      AVG:     state_d = DECIDE;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Full-width product; PITCH_MAX*(LEVELS-1) fits in NUM_W bits.
  assign num_c       = NUM_W'(pitch_q) * NUM_W'(LEVELS - 1);
  assign div_start_c = (state_q == MUL);

  seq_divider #(
    .DIVIDEND_W (NUM_W),
    .DIVISOR_W  (DIVR_W),
    .QUOT_W     (QW)
  ) u_div (
    .clk      (clk),
    .rst_n    (reset),
    .start    (div_start_c),
    .dividend (num_c),
    .divisor  (DIVR_W'(PITCH_MAX)),
    .quotient (quot),
    .done_c   (div_done_c)
  );

  assign mapped_c = MAP_W'(quot) + MAP_W'(1);
  assign avg_c    = MAP_W'(sum >> AVG_LOG2);

  // Hysteresis pulls the level toward the current speed before banding.
  always_comb begin
    avg_i    = 32'(avg_c);
    spd_i    = 32'(speed);
    band_avg = band(avg_i, STEP_LOG2, NSPEED);
    lim_i    = avg_i;
    cand_i   = spd_i;
    if (band_avg > spd_i) begin
      lim_i  = (avg_i > HYST) ? avg_i - HYST : 0;
      if (lim_i < 1) lim_i = 1;
      cand_i = band(lim_i, STEP_LOG2, NSPEED);
    end else if (band_avg < spd_i) begin
      lim_i  = avg_i + HYST;
      if (lim_i > LEVELS) lim_i = LEVELS;
      cand_i = band(lim_i, STEP_LOG2, NSPEED);
    end
    cand_c = SPD_W'(cand_i);
  end

  // Debounce: a new speed must be proposed HOLD times in a row.
  always_comb begin
    speed_nxt_c   = speed;
    pending_nxt_c = pending;
    cnt_nxt_c     = hold_cnt;
    changed_nxt_c = 1'b0;
    if (cand_c == speed) begin
      cnt_nxt_c = '0;
    end else if (cand_c != pending) begin
      cnt_nxt_c     = CNT_W'(1);
      pending_nxt_c = cand_c;
    end else begin
      cnt_nxt_c = hold_cnt + CNT_W'(1);
    end
    if ((cand_c != speed) && (cnt_nxt_c == CNT_W'(HOLD))) begin
      speed_nxt_c   = cand_c;
      changed_nxt_c = 1'b1;
      cnt_nxt_c     = '0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pitch_q      <= '0;
      wp           <= '0;
      sum          <= SUM_W'(AVG_N);
      for (int i = 0; i < AVG_N; i++) avg_buf[i] <= MAP_W'(1);
      pending      <= '0;
      hold_cnt     <= '0;
      mapped_value <= MAP_W'(1);
      avg_value    <= MAP_W'(1);
      speed        <= '0;
      out_valid    <= 1'b0;
      changed      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      changed   <= 1'b0;
      if ((state_q == IDLE) && in_valid) begin
        pitch_q <= (in_data >= PITCH_W'(PITCH_MAX)) ? PITCH_W'(PITCH_MAX) : in_data;
      end
      if (state_q == AVG) begin
        sum         <= sum - SUM_W'(avg_buf[wp]) + SUM_W'(mapped_c);
        avg_buf[wp] <= mapped_c;
        wp          <= wp + WP_W'(1);
      end
      if (state_q == DECIDE) begin
        mapped_value <= mapped_c;
        avg_value    <= avg_c;
        speed        <= speed_nxt_c;
        pending      <= pending_nxt_c;
        hold_cnt     <= cnt_nxt_c;
        out_valid    <= 1'b1;
        changed      <= changed_nxt_c;
      end
    end
  end

endmodule
